// File: rtl/lock_pkg.sv
// Shared definitions for the serial-code door lock controller:
// state encoding, fail counter width, default code and small helpers.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } lock_state_t;

    localparam int FAIL_W = 4;
    localparam logic [4:0] LOCK_DEFAULT_CODE = 5'b01011;

    function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v,
                                                  input logic [FAIL_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock, lockout and entry-timeout intervals.
// done is high while the count sits at zero.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Door lock sequencer: serial code entry, compare against a programmable code,
// timed unlock, consecutive-failure counting and timed lockout.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = CODE_LEN'(LOCK_DEFAULT_CODE),
    parameter int                  MAX_FAILS      = 3,
    parameter int                  UNLOCK_CYCLES  = 100,
    parameter int                  LOCKOUT_CYCLES = 1000,
    parameter int                  ENTRY_TIMEOUT  = 50
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                bit_valid,
    input  logic                bit_in,
    input  logic                relock,
    input  logic                prog_en,
    input  logic [CODE_LEN-1:0] prog_code,
    output logic                unlck,
    output logic                locked_out,
    output logic                entry_active,
    output logic                result_valid,
    output logic                result_ok,
    output logic [FAIL_W-1:0]   fail_cnt
);

    localparam int TW = $clog2(max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT) + 1);
    localparam int BW = $clog2(CODE_LEN + 1);

    // The timer is loaded with N-1 so the state lasts exactly N cycles.
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] ENTRY_LOAD   = TW'(ENTRY_TIMEOUT - 1);

    lock_state_t         state_reg, state_next;
    logic [CODE_LEN-1:0] sreg_reg, sreg_next;
    logic [CODE_LEN-1:0] code_reg, code_next;
    logic [CODE_LEN-1:0] cand;
    logic [BW-1:0]       bcnt_reg, bcnt_next;
    logic [FAIL_W-1:0]   fail_reg, fail_next;
    logic                unlck_reg, locked_out_reg, entry_active_reg;
    logic                result_valid_reg, result_ok_reg;
    logic                result_valid_next, result_ok_next;
    logic                tmr_load, tmr_en, tmr_done;
    logic [TW-1:0]       tmr_val;
    logic                attempt_done, attempt_ok;

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_reg        <= IDLE;
            sreg_reg         <= '0;
            code_reg         <= DEFAULT_CODE;
            bcnt_reg         <= '0;
            fail_reg         <= '0;
            unlck_reg        <= 1'b0;
            locked_out_reg   <= 1'b0;
            entry_active_reg <= 1'b0;
            result_valid_reg <= 1'b0;
            result_ok_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            sreg_reg         <= sreg_next;
            code_reg         <= code_next;
            bcnt_reg         <= bcnt_next;
            fail_reg         <= fail_next;
            unlck_reg        <= (state_next == UNLOCKED);
            locked_out_reg   <= (state_next == LOCKOUT);
            entry_active_reg <= (state_next == ENTRY);
            result_valid_reg <= result_valid_next;
            result_ok_reg    <= result_ok_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        sreg_next         = sreg_reg;
        code_next         = code_reg;
        bcnt_next         = bcnt_reg;
        fail_next         = fail_reg;
        result_valid_next = 1'b0;
        result_ok_next    = 1'b0;
        tmr_load          = 1'b0;
        tmr_val           = '0;
        tmr_en            = 1'b0;
        attempt_done      = 1'b0;
        attempt_ok        = 1'b0;
        cand              = CODE_LEN'({sreg_reg, bit_in});

        case (state_reg)
            IDLE: begin
                if (prog_en) begin
                    code_next = prog_code;
                end else if (bit_valid) begin
                    sreg_next = cand;
                    bcnt_next = BW'(1);
                    if (CODE_LEN == 1) begin
                        attempt_done = 1'b1;
                        attempt_ok   = (cand == code_reg);
                    end else begin
                        state_next = ENTRY;
                        tmr_load   = 1'b1;
                        tmr_val    = ENTRY_LOAD;
                    end
                end
            end
            ENTRY: begin
                if (bit_valid) begin
                    sreg_next = cand;
                    bcnt_next = bcnt_reg + 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = ENTRY_LOAD;
                    if (bcnt_reg == BW'(CODE_LEN - 1)) begin
                        attempt_done = 1'b1;
                        attempt_ok   = (cand == code_reg);
                    end
                end else if (tmr_done) begin
                    attempt_done = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            UNLOCKED: begin
                if (relock || tmr_done) begin
                    state_next = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_next = IDLE;
                    fail_next  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Timeouts and completed codes share the same result/fail bookkeeping.
        if (attempt_done) begin
            bcnt_next         = '0;
            result_valid_next = 1'b1;
            result_ok_next    = attempt_ok;
            if (attempt_ok) begin
                fail_next  = '0;
                state_next = UNLOCKED;
                tmr_load   = 1'b1;
                tmr_val    = UNLOCK_LOAD;
            end else begin
                fail_next = sat_inc(fail_reg, FAIL_W'(MAX_FAILS));
                if (fail_next == FAIL_W'(MAX_FAILS)) begin
                    state_next = LOCKOUT;
                    tmr_load   = 1'b1;
                    tmr_val    = LOCKOUT_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
        end
    end

    assign unlck        = unlck_reg;
    assign locked_out   = locked_out_reg;
    assign entry_active = entry_active_reg;
    assign result_valid = result_valid_reg;
    assign result_ok    = result_ok_reg;
    assign fail_cnt     = fail_reg;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random traffic, checked every
// cycle against a countdown-style behavioural model of the lock.
module tb_lock_ctrl;

    localparam int CL = 5;
    localparam int MF = 3;
    localparam int UC = 8;
    localparam int LC = 16;
    localparam int ET = 4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       relock = 1'b0;
    logic       prog_en = 1'b0;
    logic [4:0] prog_code = 5'b0;
    logic       unlck, locked_out, entry_active, result_valid, result_ok;
    logic [3:0] fail_cnt;

    always #5 clk = ~clk;

    lock_ctrl #(
        .CODE_LEN       (CL),
        .MAX_FAILS      (MF),
        .UNLOCK_CYCLES  (UC),
        .LOCKOUT_CYCLES (LC),
        .ENTRY_TIMEOUT  (ET)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .relock       (relock),
        .prog_en      (prog_en),
        .prog_code    (prog_code),
        .unlck        (unlck),
        .locked_out   (locked_out),
        .entry_active (entry_active),
        .result_valid (result_valid),
        .result_ok    (result_ok),
        .fail_cnt     (fail_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: remaining unlock/lockout cycles, bits collected so far, idle gap.
    int         m_unlock_left = 0, m_lock_left = 0, m_nbits = 0, m_val = 0, m_gap = 0, m_fails = 0;
    bit         m_in_entry = 1'b0, m_rv = 1'b0, m_rok = 1'b0, m_done, m_ok;
    logic [4:0] m_code = 5'b01011;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_unlock_left = 0; m_lock_left = 0; m_nbits = 0; m_val = 0; m_gap = 0;
            m_fails = 0; m_in_entry = 1'b0; m_rv = 1'b0; m_rok = 1'b0; m_code = 5'b01011;
        end else begin
            m_rv = 1'b0; m_rok = 1'b0; m_done = 1'b0; m_ok = 1'b0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end else if (m_unlock_left > 0) begin
                m_unlock_left = relock ? 0 : m_unlock_left - 1;
            end else if (m_in_entry) begin
                if (bit_valid) begin
                    m_val = (m_val * 2 + int'(bit_in)) % 32;
                    m_nbits++;
                    m_gap = 0;
                    if (m_nbits == CL) begin m_done = 1'b1; m_ok = (m_val == int'(m_code)); end
                end else begin
                    m_gap++;
                    if (m_gap == ET) m_done = 1'b1;
                end
            end else if (prog_en) begin
                m_code = prog_code;
            end else if (bit_valid) begin
                m_in_entry = 1'b1; m_nbits = 1; m_val = int'(bit_in); m_gap = 0;
            end
            if (m_done) begin
                m_in_entry = 1'b0; m_rv = 1'b1; m_rok = m_ok;
                if (m_ok) begin
                    m_fails = 0; m_unlock_left = UC;
                end else begin
                    if (m_fails < MF) m_fails++;
                    if (m_fails == MF) m_lock_left = LC;
                end
            end
        end
    end

    logic [8:0] exp_vec, act_vec;
    assign exp_vec = {m_unlock_left > 0, m_lock_left > 0, m_in_entry, m_rv, m_rok, 4'(m_fails)};
    assign act_vec = {unlck, locked_out, entry_active, result_valid, result_ok, fail_cnt};

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t {unlck,lo,ea,rv,ok,fail} actual=%b required=%b",
                         $time, act_vec, exp_vec);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end else begin
            $display("ok   %s t=%0t value=%0h", name, $time, act);
        end
    endtask

    task automatic cyc(input logic bv, input logic b, input logic rl, input logic pe,
                       input logic [4:0] pc);
        bit_valid = bv; bit_in = b; relock = rl; prog_en = pe; prog_code = pc;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b0);
    endtask

    task automatic send_code(input logic [4:0] c);
        for (int i = 4; i >= 0; i--) cyc(1'b1, c[i], 1'b0, 1'b0, 5'b0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((unlck || locked_out || entry_active) && g < 200) begin
            idle(1);
            g++;
        end
        check("wait_idle_bound", 16'(g < 200), 16'd1);
    endtask

    int cnt;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 16'(act_vec), 16'd0);
        Reset = 1'b0;
        chk_en = 1'b1;

        // 1. correct default code
        send_code(5'b01011);
        check("t1_result_valid", 16'(result_valid), 16'd1);
        check("t1_result_ok", 16'(result_ok), 16'd1);
        cnt = 0;
        while (unlck && cnt < 40) begin cnt++; idle(1); end
        check("t1_unlock_cycles", 16'(cnt), 16'(UC));
        check("t1_fail_cnt", 16'(fail_cnt), 16'd0);

        // 2. three failures then lockout
        for (int k = 1; k <= 3; k++) begin
            send_code(5'b11111);
            check($sformatf("t2_fail_cnt_%0d", k), 16'(fail_cnt), 16'(k));
        end
        check("t2_locked_out", 16'(locked_out), 16'd1);
        cnt = 0;
        for (int i = 4; i >= 0; i--) begin
            if (locked_out) cnt++;
            cyc(1'b1, i == 3 || i == 1 || i == 0, 1'b0, 1'b0, 5'b0);
        end
        while (locked_out && cnt < 60) begin cnt++; idle(1); end
        check("t2_lockout_cycles", 16'(cnt), 16'(LC));
        check("t2_no_unlock", 16'(unlck), 16'd0);
        check("t2_fail_after_exit", 16'(fail_cnt), 16'd0);
        send_code(5'b01011);
        check("t2_unlock_after", 16'(unlck), 16'd1);
        wait_idle();

        // 3. entry timeout
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b0);
        idle(3);
        check("t3_still_entry", 16'(entry_active), 16'd1);
        idle(1);
        check("t3_timeout_rv", 16'(result_valid), 16'd1);
        check("t3_timeout_ok", 16'(result_ok), 16'd0);
        check("t3_fail_cnt", 16'(fail_cnt), 16'd1);
        check("t3_left_entry", 16'(entry_active), 16'd0);
        send_code(5'b01011);
        check("t3_unlock", 16'(unlck), 16'd1);
        wait_idle();

        // 4. programming
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'b10010);
        check("t4_bit_dropped", 16'(entry_active), 16'd0);
        send_code(5'b01011);
        check("t4_old_code_rejected", 16'({result_valid, result_ok}), 16'b10);
        send_code(5'b10010);
        check("t4_new_code_ok", 16'({result_valid, result_ok}), 16'b11);
        wait_idle();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'b01011);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'b0);
        check("t4_prog_in_entry_ignored", 16'(unlck), 16'd1);
        wait_idle();

        // 5. relock
        send_code(5'b10010);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'b0);
        check("t5_relock", 16'(unlck), 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'b0);
        check("t5_relock_idle", 16'({unlck, entry_active, locked_out}), 16'd0);

        // 6. async reset in the middle of lockout
        for (int k = 0; k < 3; k++) send_code(5'b11111);
        idle(5);
        check("t6_pre_locked", 16'(locked_out), 16'd1);
        #2 Reset = 1'b1;
        #1 check("t6_async_clear", 16'(act_vec), 16'd0);
        @(negedge clk);
        Reset = 1'b0;
        check("t6_fail_after_reset", 16'(fail_cnt), 16'd0);
        send_code(5'b01011);
        check("t6_default_code", 16'(unlck), 16'd1);
        wait_idle();

        // random traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    logic [4:0] c;
                    c = m_code;
                    for (int i = 4; i >= 0; i--) begin
                        cyc(1'b1, c[i], 1'b0, 1'b0, 5'b0);
                        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 5));
                    end
                end
                1: send_code(5'($urandom));
                2: idle($urandom_range(1, 10));
                3: cyc(1'($urandom), 1'($urandom), 1'b0, 1'b1,
                       ($urandom_range(0, 1) == 0) ? 5'b01011 : 5'($urandom));
                4: cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'b0);
                default: cyc(1'($urandom), 1'($urandom), 1'($urandom),
                             ($urandom_range(0, 3) == 0), 5'($urandom));
            endcase
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
